// File: rtl/systolic_sched.sv
// systolic_sched: sequencer between scratch memory and systolic_array.
// Loads N weight rows and N im2col rows into local buffers. It then resets
// the array and feeds one X/W row per cycle. When the array reports done, it
// writes the M*K results back to memory and pulses done.
// Ports: clk, rst_systolic (async, active-low), start/busy/done handshake,
//   addr_rd/data_rd memory read (1-cycle latency), addr_wr/data_wr/mem_wr_en
//   memory write, sa_rst_n/X/W/Y/sa_done systolic_array interface.
module systolic_sched #(
  parameter int unsigned M          = 9,
  parameter int unsigned N          = 1,
  parameter int unsigned K          = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(32'h1000),
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(32'h2000),
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(32'h3000)
) (
  input  logic                           clk,
  input  logic                           rst_systolic,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          addr_rd,
  input  logic [DATA_WIDTH-1:0]          data_rd,
  output logic [ADDR_WIDTH-1:0]          addr_wr,
  output logic [DATA_WIDTH-1:0]          data_wr,
  output logic                           mem_wr_en,
  output logic                           sa_rst_n,
  output logic [DATA_WIDTH*M-1:0]        X,
  output logic [DATA_WIDTH*K-1:0]        W,
  input  logic [DATA_WIDTH*M*K-1:0]      Y,
  input  logic                           sa_done
);

  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned NK      = N * K;
  localparam int unsigned NM      = N * M;
  localparam int unsigned MK      = M * K;
  localparam int unsigned MAX_A   = (NM > MK) ? NM : MK;
  localparam int unsigned CNT_MAX = (MAX_A > NK) ? MAX_A : NK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_X, S_ARM, S_FEED, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cap_vld_q, cap_vld_d;
  logic                 cap_x_q, cap_x_d;
  logic [CNT_W-1:0]     cap_idx_q, cap_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic [DW-1:0]        data_wr_q, data_wr_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 sa_rst_n_q, sa_rst_n_d;
  logic [DW*M-1:0]      x_q, x_d;
  logic [DW*K-1:0]      w_q, w_d;

  logic [DW*K-1:0]      w_buf_q [N];
  logic [DW*K-1:0]      w_buf_d [N];
  logic [DW*M-1:0]      x_buf_q [N];
  logic [DW*M-1:0]      x_buf_d [N];
  logic [DW*M*K-1:0]    y_buf_q, y_buf_d;

  // Next-state, buffer capture and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rd_vld_d    = 1'b0;
    cnt_d       = cnt_q;
    cap_vld_d   = rd_vld_q;
    cap_x_d     = (state_q == S_LOAD_X);
    cap_idx_d   = cnt_q;
    done_d      = 1'b0;
    addr_rd_d   = '0;
    addr_wr_d   = '0;
    data_wr_d   = '0;
    mem_wr_en_d = 1'b0;
    sa_rst_n_d  = sa_rst_n_q;
    x_d         = '0;
    w_d         = w_q;
    w_buf_d     = w_buf_q;
    x_buf_d     = x_buf_q;
    y_buf_d     = y_buf_q;

    // Read data arrives one cycle after its address; file it by issue index.
    if (cap_vld_q) begin
      if (cap_x_q) begin
        for (int unsigned r = 0; r < N; r++)
          for (int unsigned c = 0; c < M; c++)
            if (cap_idx_q == CNT_W'(r*M + c)) x_buf_d[r][c*DW +: DW] = data_rd;
      end else begin
        for (int unsigned r = 0; r < N; r++)
          for (int unsigned c = 0; c < K; c++)
            if (cap_idx_q == CNT_W'(r*K + c)) w_buf_d[r][c*DW +: DW] = data_rd;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD_W;
          rd_vld_d   = 1'b1;
          cnt_d      = '0;
          addr_rd_d  = WEIGHT_BASE;
          sa_rst_n_d = 1'b0;
        end
      end
      S_LOAD_W: begin
        rd_vld_d = 1'b1;
        if (cnt_q == CNT_W'(NK - 1)) begin
          state_d   = S_LOAD_X;
          cnt_d     = '0;
          addr_rd_d = IM2COL_BASE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          addr_rd_d = addr_rd_q + ADDR_WIDTH'(1);
        end
      end
      S_LOAD_X: begin
        if (rd_vld_q) begin
          if (cnt_q != CNT_W'(NM - 1)) begin
            rd_vld_d  = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            addr_rd_d = addr_rd_q + ADDR_WIDTH'(1);
          end
        end else begin
          // Drain cycle: last word lands this cycle, array is held next.
          state_d    = S_ARM;
          sa_rst_n_d = 1'b0;
          w_d        = '0;
        end
      end
      S_ARM: begin
        state_d    = S_FEED;
        sa_rst_n_d = 1'b1;
        cnt_d      = '0;
        x_d        = x_buf_q[0];
        w_d        = w_buf_q[0];
      end
      S_FEED: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          for (int unsigned r = 0; r < N; r++)
            if (cnt_q + CNT_W'(1) == CNT_W'(r)) begin
              x_d = x_buf_q[r];
              w_d = w_buf_q[r];
            end
        end
      end
      S_WAIT: begin
        if (sa_done) begin
          state_d     = S_WB;
          y_buf_d     = Y;
          cnt_d       = '0;
          mem_wr_en_d = 1'b1;
          addr_wr_d   = OUTPUT_BASE;
          data_wr_d   = Y[DW-1:0];
        end
      end
      S_WB: begin
        if (cnt_q == CNT_W'(MK - 1)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          sa_rst_n_d = 1'b0;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mem_wr_en_d = 1'b1;
          addr_wr_d   = OUTPUT_BASE + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
          for (int unsigned i = 0; i < MK; i++)
            if (cnt_q + CNT_W'(1) == CNT_W'(i)) data_wr_d = y_buf_q[i*DW +: DW];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) begin
      state_q     <= S_IDLE;
      rd_vld_q    <= 1'b0;
      cnt_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_x_q     <= 1'b0;
      cap_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_rd_q   <= '0;
      addr_wr_q   <= '0;
      data_wr_q   <= '0;
      mem_wr_en_q <= 1'b0;
      sa_rst_n_q  <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      cnt_q       <= cnt_d;
      cap_vld_q   <= cap_vld_d;
      cap_x_q     <= cap_x_d;
      cap_idx_q   <= cap_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_rd_q   <= addr_rd_d;
      addr_wr_q   <= addr_wr_d;
      data_wr_q   <= data_wr_d;
      mem_wr_en_q <= mem_wr_en_d;
      sa_rst_n_q  <= sa_rst_n_d;
      x_q         <= x_d;
      w_q         <= w_d;
    end
  end

  // Data buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    w_buf_q <= w_buf_d;
    x_buf_q <= x_buf_d;
    y_buf_q <= y_buf_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_rd   = addr_rd_q;
  assign addr_wr   = addr_wr_q;
  assign data_wr   = data_wr_q;
  assign mem_wr_en = mem_wr_en_q;
  assign sa_rst_n  = sa_rst_n_q;
  assign X         = x_q;
  assign W         = w_q;

endmodule
